// File: rtl/pad_user_gen_pkg.sv
// Shared definitions for the pad user-flag generator: TUSER bit layout and
// the frame sequencer state.
package pad_user_gen_pkg;

  localparam int TUSER_WIDTH        = 4;
  localparam int INDEX_IS_1x1       = 0;
  localparam int INDEX_IS_COL_FIRST = 1;
  localparam int INDEX_IS_COL_LAST  = 2;
  localparam int INDEX_IS_COLS_1_K2 = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pad_user_gen_axis_reg.sv
// Single-stage AXI-Stream output register. It can take a new beat whenever it
// is empty or its current beat leaves in the same cycle.
module pad_user_axis_reg #(
  parameter int DATA_WIDTH  = 16,
  parameter int TUSER_WIDTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic [TUSER_WIDTH-1:0] load_user,
  input  logic                   load_last,
  output logic                   can_load,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [TUSER_WIDTH-1:0] m_user,
  output logic                   m_last
);

  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;
  logic                   last_q, last_d;

  assign can_load = ~valid_q | m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    last_d  = last_q;
    if (aclken) begin
      if (load) begin
        valid_d = 1'b1;
        data_d  = load_data;
        user_d  = load_user;
        last_d  = load_last;
      end else if (valid_q && m_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_user  = user_q;
  assign m_last  = last_q;

endmodule

// File: rtl/pad_user_gen.sv
// Counts columns/rows of a raster stream against a configuration latched on
// start and tags every beat with the position flags used by the pad filter.
module pad_user_gen #(
  parameter int DATA_WIDTH         = 16,
  parameter int KERNEL_W_MAX       = 7,
  parameter int COLS_MAX           = 1024,
  parameter int ROWS_MAX           = 1024,
  parameter int TUSER_WIDTH        = pad_user_gen_pkg::TUSER_WIDTH,
  parameter int INDEX_IS_1x1       = pad_user_gen_pkg::INDEX_IS_1x1,
  parameter int INDEX_IS_COL_FIRST = pad_user_gen_pkg::INDEX_IS_COL_FIRST,
  parameter int INDEX_IS_COL_LAST  = pad_user_gen_pkg::INDEX_IS_COL_LAST,
  parameter int INDEX_IS_COLS_1_K2 = pad_user_gen_pkg::INDEX_IS_COLS_1_K2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                aclken,
  input  logic                                start,
  input  logic [$clog2(KERNEL_W_MAX+1)-1:0]   kernel_w_1_in,
  input  logic [$clog2(COLS_MAX)-1:0]         cols_1_in,
  input  logic [$clog2(ROWS_MAX)-1:0]         rows_1_in,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [TUSER_WIDTH-1:0]              m_user,
  output logic                                m_last,
  output logic                                busy
);

  import pad_user_gen_pkg::*;

  localparam int KW_W  = $clog2(KERNEL_W_MAX + 1);
  localparam int COL_W = $clog2(COLS_MAX);
  localparam int ROW_W = $clog2(ROWS_MAX);

  state_e           state_q, state_d;
  logic [KW_W-1:0]  kw_1_q, kw_1_d;
  logic [COL_W-1:0] cols_1_q, cols_1_d;
  logic [ROW_W-1:0] rows_1_q, rows_1_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic                   can_load;
  logic                   accept;
  logic                   is_1x1;
  logic                   col_last;
  logic                   row_last;
  logic [COL_W-1:0]       half_kw;
  logic [COL_W-1:0]       edge_col;
  logic [TUSER_WIDTH-1:0] user_next;

  assign s_ready  = aclken & (state_q == RUN) & can_load;
  assign accept   = s_valid & s_ready;
  assign busy     = (state_q == RUN);

  assign is_1x1   = (kw_1_q == '0);
  assign col_last = (col_q == cols_1_q);
  assign row_last = (row_q == rows_1_q);

  // Right-edge column where padding starts; saturates at column 0 when the
  // half-kernel is wider than the image.
  assign half_kw  = COL_W'(kw_1_q >> 1);
  assign edge_col = (half_kw > cols_1_q) ? '0 : (cols_1_q - half_kw);

  always_comb begin
    user_next                     = '0;
    user_next[INDEX_IS_1x1]       = is_1x1;
    user_next[INDEX_IS_COL_FIRST] = (col_q == '0);
    user_next[INDEX_IS_COL_LAST]  = col_last;
    user_next[INDEX_IS_COLS_1_K2] = ~is_1x1 & (col_q == edge_col);
  end

  always_comb begin
    state_d  = state_q;
    kw_1_d   = kw_1_q;
    cols_1_d = cols_1_q;
    rows_1_d = rows_1_q;
    col_d    = col_q;
    row_d    = row_q;
    if (aclken) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            kw_1_d   = kernel_w_1_in;
            cols_1_d = cols_1_in;
            rows_1_d = rows_1_in;
            col_d    = '0;
            row_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            col_d = col_last ? '0 : (col_q + 1'b1);
            if (col_last) begin
              row_d = row_last ? '0 : (row_q + 1'b1);
            end
            if (col_last && row_last) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      kw_1_q   <= '0;
      cols_1_q <= '0;
      rows_1_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      kw_1_q   <= kw_1_d;
      cols_1_q <= cols_1_d;
      rows_1_q <= rows_1_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

  pad_user_axis_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .TUSER_WIDTH(TUSER_WIDTH)
  ) u_out_reg (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .aclken   (aclken),
    .load     (accept),
    .load_data(s_data),
    .load_user(user_next),
    .load_last(col_last & row_last),
    .can_load (can_load),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_user   (m_user),
    .m_last   (m_last)
  );

endmodule

// File: tb/tb_pad_user_gen.sv
// Directed bench for pad_user_gen: one task per scenario, expected flags
// written out by hand per beat.
module tb_pad_user_gen;

  logic        aclk;
  logic        aresetn;
  logic        aclken;
  logic        start;
  logic [2:0]  kernel_w_1_in;
  logic [9:0]  cols_1_in;
  logic [9:0]  rows_1_in;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [3:0]  m_user;
  logic        m_last;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;

  logic [15:0] q_data[$];
  logic [3:0]  q_user[$];
  logic        q_last[$];

  pad_user_gen dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .aclken       (aclken),
    .start        (start),
    .kernel_w_1_in(kernel_w_1_in),
    .cols_1_in    (cols_1_in),
    .rows_1_in    (rows_1_in),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_user       (m_user),
    .m_last       (m_last),
    .busy         (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cycle_cnt <= cycle_cnt + 1;

  // Output transfers are recorded half a cycle before the edge that takes them.
  always @(negedge aclk) begin
    if (aresetn && aclken && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_user.push_back(m_user);
      q_last.push_back(m_last);
      $display("beat out: data=%h user=%b last=%b", m_data, m_user, m_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic clear_q();
    q_data.delete();
    q_user.delete();
    q_last.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_start(input int kw, input int cols, input int rows);
    kernel_w_1_in = 3'(kw);
    cols_1_in     = 10'(cols);
    rows_1_in     = 10'(rows);
    start         = 1'b1;
    tick(1);
    start         = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] d, output bit ok);
    bit acc;
    int cyc;
    acc     = 1'b0;
    cyc     = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && cyc < 60) begin
      @(negedge aclk);
      acc = s_ready;
      @(posedge aclk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    ok      = acc;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    tick(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tick(1);
    end
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b expected 0", s_ready); end
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid: got %b expected 0", m_valid); end
      tick(1);
    end
    s_valid = 1'b0;
    checks++;
    if (q_data.size() != 0) begin errors++; $display("FAIL idle_no_beats: got %0d expected 0", q_data.size()); end
    $display("test_reset done");
  endtask

  task automatic test_frame();
    logic [3:0] exp_u [12] = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h4,
                               4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h4};
    bit ok;
    int t0;
    clear_q();
    m_ready = 1'b1;
    do_start(4, 5, 1);
    t0 = cycle_cnt;
    for (int i = 0; i < 12; i++) begin
      drive_beat(16'(i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL frame_accept: beat %0d not accepted", i); end
    end
    checks++;
    if (cycle_cnt - t0 != 12) begin errors++; $display("FAIL frame_throughput: got %0d cycles expected 12", cycle_cnt - t0); end
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b expected 0", busy); end
    checks++;
    if (m_valid !== 1'b1 || m_last !== 1'b1) begin
      errors++; $display("FAIL frame_final_held: got valid=%b last=%b expected 1 1", m_valid, m_last);
    end
    tick(3);
    checks++;
    if (q_data.size() != 12) begin errors++; $display("FAIL frame_count: got %0d expected 12", q_data.size()); end
    for (int i = 0; i < 12 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 16'(i)) begin errors++; $display("FAIL frame_data[%0d]: got %h expected %h", i, q_data[i], 16'(i)); end
      checks++;
      if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL frame_user[%0d]: got %b expected %b", i, q_user[i], exp_u[i]); end
      checks++;
      if (q_last[i] !== (i == 11)) begin errors++; $display("FAIL frame_last[%0d]: got %b expected %b", i, q_last[i], (i == 11)); end
    end
    // A second frame must not start without a fresh start pulse.
    s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_needs_start: got %b expected 0", s_ready); end
      tick(1);
    end
    s_valid = 1'b0;
    $display("test_frame done");
  endtask

  task automatic test_1x1();
    logic [3:0] exp_u [4] = '{4'h3, 4'h1, 4'h1, 4'h5};
    bit ok;
    clear_q();
    m_ready = 1'b1;
    do_start(0, 3, 0);
    for (int i = 0; i < 4; i++) begin
      drive_beat(16'(16'h100 + i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL k1_accept: beat %0d not accepted", i); end
    end
    tick(3);
    checks++;
    if (q_data.size() != 4) begin errors++; $display("FAIL k1_count: got %0d expected 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 16'(16'h100 + i)) begin errors++; $display("FAIL k1_data[%0d]: got %h expected %h", i, q_data[i], 16'(16'h100 + i)); end
      checks++;
      if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL k1_user[%0d]: got %b expected %b", i, q_user[i], exp_u[i]); end
      checks++;
      if (q_last[i] !== (i == 3)) begin errors++; $display("FAIL k1_last[%0d]: got %b expected %b", i, q_last[i], (i == 3)); end
    end
    $display("test_1x1 done");
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_u [4] = '{4'h2, 4'h0, 4'h8, 4'h4};
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_q();
    m_ready = 1'b1;
    do_start(2, 3, 0);
    fork
      begin
        bit ok;
        for (int i = 0; i < 4; i++) begin
          drive_beat(16'(16'hA0 + i), ok);
          checks++;
          if (!ok) begin errors++; $display("FAIL bp_accept: beat %0d not accepted", i); end
        end
      end
      begin
        logic        pv, pr;
        logic [15:0] pd;
        logic [3:0]  pu;
        pv = 1'b0;
        pr = 1'b1;
        pd = '0;
        pu = '0;
        for (int k = 0; k < 20; k++) begin
          m_ready = pat[k % 4];
          @(negedge aclk);
          if (pv && !pr) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== pd || m_user !== pu) begin
              errors++;
              $display("FAIL bp_hold: got v=%b d=%h u=%b expected v=1 d=%h u=%b", m_valid, m_data, m_user, pd, pu);
            end
          end
          if (m_valid && !m_ready) begin
            checks++;
            if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b expected 0", s_ready); end
          end
          pv = m_valid;
          pr = m_ready;
          pd = m_data;
          pu = m_user;
          tick(1);
        end
        m_ready = 1'b1;
      end
    join
    tick(3);
    checks++;
    if (q_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 16'(16'hA0 + i)) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, q_data[i], 16'(16'hA0 + i)); end
      checks++;
      if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL bp_user[%0d]: got %b expected %b", i, q_user[i], exp_u[i]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_clamp_edges();
    int         kw [3] = '{6, 3, 0};
    int         cl [3] = '{1, 0, 0};
    int         rw [3] = '{0, 1, 0};
    int         nb [3] = '{2, 2, 1};
    logic [3:0] eu [3][2] = '{'{4'hA, 4'h4}, '{4'hE, 4'hE}, '{4'h7, 4'h0}};
    bit ok;
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      clear_q();
      do_start(kw[f], cl[f], rw[f]);
      for (int i = 0; i < nb[f]; i++) begin
        drive_beat(16'(16'h200 + 16 * f + i), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL edge_accept: frame %0d beat %0d not accepted", f, i); end
      end
      tick(3);
      checks++;
      if (q_data.size() != nb[f]) begin errors++; $display("FAIL edge_count[%0d]: got %0d expected %0d", f, q_data.size(), nb[f]); end
      for (int i = 0; i < nb[f] && i < q_data.size(); i++) begin
        checks++;
        if (q_user[i] !== eu[f][i]) begin errors++; $display("FAIL edge_user[%0d][%0d]: got %b expected %b", f, i, q_user[i], eu[f][i]); end
        checks++;
        if (q_last[i] !== (i == nb[f] - 1)) begin errors++; $display("FAIL edge_last[%0d][%0d]: got %b expected %b", f, i, q_last[i], (i == nb[f] - 1)); end
      end
    end
    $display("test_clamp_edges done");
  endtask

  task automatic test_mid_start();
    logic [3:0] exp_u [6] = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h4};
    bit ok;
    clear_q();
    m_ready = 1'b1;
    do_start(4, 5, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        kernel_w_1_in = 3'd0;
        cols_1_in     = 10'd1;
        rows_1_in     = 10'd0;
        start         = 1'b1;
      end
      drive_beat(16'(16'h30 + i), ok);
      start = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_start_accept: beat %0d not accepted", i); end
    end
    tick(3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_start_busy: got %b expected 0", busy); end
    checks++;
    if (q_data.size() != 6) begin errors++; $display("FAIL mid_start_count: got %0d expected 6", q_data.size()); end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      checks++;
      if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL mid_start_user[%0d]: got %b expected %b", i, q_user[i], exp_u[i]); end
      checks++;
      if (q_last[i] !== (i == 5)) begin errors++; $display("FAIL mid_start_last[%0d]: got %b expected %b", i, q_last[i], (i == 5)); end
    end
    $display("test_mid_start done");
  endtask

  task automatic test_clken();
    logic [3:0] exp_u [6] = '{4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h4};
    bit ok;
    clear_q();
    m_ready = 1'b1;
    do_start(4, 5, 0);
    for (int i = 0; i < 3; i++) begin
      drive_beat(16'(16'h40 + i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clken_accept: beat %0d not accepted", i); end
    end
    s_valid = 1'b1;
    s_data  = 16'h0043;
    aclken  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL clken_s_ready: got %b expected 0", s_ready); end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0042 || m_user !== 4'h0 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL clken_frozen: got v=%b d=%h u=%b l=%b expected v=1 d=0042 u=0000 l=0", m_valid, m_data, m_user, m_last);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL clken_busy: got %b expected 1", busy); end
      tick(1);
    end
    aclken = 1'b1;
    for (int i = 3; i < 6; i++) begin
      drive_beat(16'(16'h40 + i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL clken_accept: beat %0d not accepted", i); end
    end
    tick(3);
    checks++;
    if (q_data.size() != 6) begin errors++; $display("FAIL clken_count: got %0d expected 6", q_data.size()); end
    for (int i = 0; i < 6 && i < q_data.size(); i++) begin
      checks++;
      if (q_data[i] !== 16'(16'h40 + i)) begin errors++; $display("FAIL clken_data[%0d]: got %h expected %h", i, q_data[i], 16'(16'h40 + i)); end
      checks++;
      if (q_user[i] !== exp_u[i]) begin errors++; $display("FAIL clken_user[%0d]: got %b expected %b", i, q_user[i], exp_u[i]); end
    end
    $display("test_clken done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_q();
    m_ready = 1'b1;
    do_start(4, 5, 1);
    for (int i = 0; i < 3; i++) begin
      drive_beat(16'(16'h50 + i), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_mid_accept: beat %0d not accepted", i); end
    end
    start   = 1'b1;
    aresetn = 1'b0;
    tick(1);
    start   = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 16'h0 || m_user !== 4'h0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b d=%h u=%b l=%b expected all 0", m_valid, m_data, m_user, m_last);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    aresetn = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: got busy=%b expected 0", busy); end
    clear_q();
    do_start(0, 0, 0);
    drive_beat(16'h0077, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_single_accept: beat not accepted"); end
    tick(3);
    checks++;
    if (q_data.size() != 1) begin
      errors++; $display("FAIL rst_single_count: got %0d expected 1", q_data.size());
    end else begin
      checks++;
      if (q_data[0] !== 16'h0077 || q_user[0] !== 4'h7 || q_last[0] !== 1'b1) begin
        errors++;
        $display("FAIL rst_single_beat: got d=%h u=%b l=%b expected d=0077 u=0111 l=1", q_data[0], q_user[0], q_last[0]);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    aresetn       = 1'b0;
    aclken        = 1'b1;
    start         = 1'b0;
    kernel_w_1_in = '0;
    cols_1_in     = '0;
    rows_1_in     = '0;
    s_valid       = 1'b0;
    s_data        = '0;
    m_ready       = 1'b1;
    test_reset();
    test_frame();
    test_1x1();
    test_backpressure();
    test_clamp_edges();
    test_mid_start();
    test_clken();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
